dmem_ctrl: RTL
==============

Name: dmem_ctrl

Overview:
- Data-memory access unit sitting directly downstream of the single-cycle CPU core's DMEM port.
- Converts the core's one-cycle load/store request (dm_ena/dm_r/dm_w, dm_addr, dm_data_w, eight size flags) into a req/ack handshake to a word-wide synchronous SRAM with byte enables.
- Returns formatted load data and stalls the core while a bus cycle is outstanding.
- Detects misaligned accesses and bus timeouts.

Parameters:
- MEM_AW, 11, word-address width of SRAM (mem_addr = dm_addr[MEM_AW+1:2]).
- TIMEOUT_CYC, 16, maximum cycles in REQ without mem_ack before bus_err.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  core enable; the core commits only when ena=1.
- dm_ena  in  1  access request from core.
- dm_r  in  1  read request.
- dm_w  in  1  write request.
- dm_addr  in  32  byte address.
- dm_data_w  in  32  store data (rt).
- sb_flag, sh_flag, sw_flag  in  1 each  store size.
- lb_flag, lh_flag, lbu_flag, lhu_flag, lw_flag  in  1 each  load size/sign.
- dm_data  out  32  formatted load data to core.
- stall  out  1  hold core PC/regfile/HI-LO/CP0 while 1.
- addr_err  out  1  one-cycle pulse: misaligned or illegal flag combination.
- bus_err  out  1  one-cycle pulse: SRAM timeout.
- mem_req  out  1  SRAM request, held until ack.
- mem_we  out  1  1 = write.
- mem_be  out  4  byte enables, bit i = byte lane i (little-endian).
- mem_addr  out  MEM_AW  word address.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  SRAM read word, valid with mem_ack.
- mem_ack  in  1  SRAM completion.

Behaviour:
- Reset (rst=0, async): state IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, addr_err, bus_err, captured data, and timeout counter all 0.
- Launch condition: IDLE & ena & dm_ena & (dm_r | dm_w).
- stall = launch | (state==REQ). stall is combinational and is 0 in DONE and ERR.
- Registered on launch edge: addr, size/sign, we, wdata.
- States:
  - IDLE: on launch with legal alignment, go to REQ; with illegal alignment or flags, go to ERR. No bus cycle on error.
  - REQ: mem_req=1 with all bus outputs stable. On mem_ack, capture mem_rdata (loads) and go to DONE. If the counter reaches TIMEOUT_CYC-1 without ack, drop req and go to DONE with bus_err=1 and captured data=0.
  - DONE: dm_data valid; the core commits on this edge when ena=1. If ena=0, stay in DONE. Return to IDLE on ena=1.
  - ERR: addr_err=1 and dm_data=0 for exactly the cycle the core commits (same ena rule as DONE). Store is suppressed. Return to IDLE.
- Latency: best case 3 cycles (launch, REQ with same-cycle ack, DONE). Back-to-back accesses launch in the IDLE cycle immediately after DONE.
- Alignment:
  - SH/LH/LHU require addr[0]=0.
  - SW/LW require addr[1:0]=0.
  - SB/LB/LBU are always legal.
  - Illegal: zero flags set, or more than one flag set, or a store flag with dm_r, or a load flag with dm_w.
- Store lanes (off = addr[1:0]):
  - SB: be = 1<<off, wdata = {4{rt[7:0]}}.
  - SH: be = off[1] ? 1100 : 0011, wdata = {2{rt[15:0]}}.
  - SW: be = 1111, wdata = rt.
- Loads: be = 1111. Select the byte or half by off, then sign-extend (LB, LH) or zero-extend (LBU, LHU). LW passes the word through.
- Outside DONE, dm_data = 0.
- ena dropping mid-REQ does not abort the bus cycle; the transaction completes and waits in DONE.
- mem_ack while not in REQ is ignored.
- Reset mid-transaction drops mem_req immediately. The SRAM tolerates an abandoned request.

Decomposition:
- Package dmem_pkg:
  - State encoding: IDLE, REQ, DONE, ERR.
  - Access-size enum: BYTE, HALF, WORD plus a sign bit.
  - Byte-enable constants.
  - Flag-to-size decode function.
- One combinational sub-module dmem_lane: store alignment (be, wdata) and load extraction/extension. The FSM and counter stay in dmem_ctrl.

Test Plan:
- SW at 0x10, rt=0xDEADBEEF, ack in REQ cycle 1 → mem_be=1111, mem_addr=4, mem_wdata=0xDEADBEEF; stall high 2 cycles, DONE on cycle 3.
- SB at 0x13, rt=0x000000A5 → mem_be=1000, mem_wdata=0xA5A5A5A5. Follow with LB at 0x13, SRAM returns 0xA5000000 → dm_data=0xFFFFFFA5. LBU at 0x13 → dm_data=0x000000A5.
- LH at 0x12, rdata=0x8001_7FFF → dm_data=0xFFFF8001. LHU at 0x10 → dm_data=0x00007FFF.
- LW at 0x06 → no mem_req, addr_err=1 for one cycle, dm_data=0. Also drive lw_flag with lb_flag both set → addr_err=1.
- LW with mem_ack withheld 20 cycles → mem_req drops after 16 cycles in REQ, bus_err pulses once, dm_data=0, stall releases. A late ack is ignored.
- ena=0 during REQ, ack arrives → state holds DONE until ena=1. Assert rst low mid-REQ → mem_req=0 immediately, state IDLE, stall=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory access unit: FSM states, access sizes,
// byte-enable constants and the core-flag decoder.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    typedef struct packed {
        size_t size;
        logic  sgn;
        logic  store;
        logic  ok;
    } acc_t;

    localparam logic [3:0] BE_ALL = 4'b1111;
    localparam logic [3:0] BE_LO  = 4'b0011;
    localparam logic [3:0] BE_HI  = 4'b1100;

    // f = {lw, lhu, lbu, lh, lb, sw, sh, sb}; ok requires exactly one flag
    // and a flag direction that agrees with dm_r/dm_w.
    function automatic acc_t decode_flags(input logic [7:0] f, input logic rd, input logic wr);
        acc_t a;
        a.store = |f[2:0];
        a.sgn   = f[3] | f[4];
        a.size  = (f[2] | f[7])        ? SZ_WORD :
                  (f[1] | f[4] | f[6]) ? SZ_HALF : SZ_BYTE;
        a.ok    = (f != 8'd0) && ((f & (f - 8'd1)) == 8'd0) &&
                  !(a.store && rd) && !(!a.store && wr);
        return a;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering: store lane placement/replication and load
// extraction with sign or zero extension.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [1:0]  st_off,
    input  size_t       st_size,
    input  logic [31:0] rt,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [1:0]  ld_off,
    input  size_t       ld_size,
    input  logic        ld_sgn,
    input  logic [31:0] rdata,
    output logic [31:0] ldata
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        be    = BE_ALL;
        wdata = rt;
        case (st_size)
            SZ_BYTE: begin
                be    = 4'b0001 << st_off;
                wdata = {4{rt[7:0]}};
            end
            SZ_HALF: begin
                be    = st_off[1] ? BE_HI : BE_LO;
                wdata = {2{rt[15:0]}};
            end
            default: begin
                be    = BE_ALL;
                wdata = rt;
            end
        endcase
    end

    always_comb begin
        ld_byte = rdata[{ld_off, 3'b000} +: 8];
        ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
        case (ld_size)
            SZ_BYTE: ldata = {{24{ld_sgn & ld_byte[7]}}, ld_byte};
            SZ_HALF: ldata = {{16{ld_sgn & ld_half[15]}}, ld_half};
            default: ldata = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access unit: turns the core's single-cycle load/store into an
// SRAM req/ack cycle, stalls the core meanwhile, flags misalignment/timeouts.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int MEM_AW      = 11,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              dm_ena,
    input  logic              dm_r,
    input  logic              dm_w,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_data_w,
    input  logic              sb_flag,
    input  logic              sh_flag,
    input  logic              sw_flag,
    input  logic              lb_flag,
    input  logic              lh_flag,
    input  logic              lbu_flag,
    input  logic              lhu_flag,
    input  logic              lw_flag,
    output logic [31:0]       dm_data,
    output logic              stall,
    output logic              addr_err,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t             state, state_nx;
    acc_t               acc;
    logic               launch, misalign, tmo;
    logic [1:0]         off_q;
    size_t              size_q;
    logic               sgn_q;
    logic [31:0]        data_q;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         st_be;
    logic [31:0]        st_wdata, ld_data;
    logic               unused_addr_hi;

    assign unused_addr_hi = ^dm_addr[31:MEM_AW+2];

    always_comb begin
        acc = decode_flags({lw_flag, lhu_flag, lbu_flag, lh_flag,
                            lb_flag, sw_flag, sh_flag, sb_flag}, dm_r, dm_w);
        misalign = (acc.size == SZ_HALF && dm_addr[0]) ||
                   (acc.size == SZ_WORD && dm_addr[1:0] != 2'b00);
        launch   = (state == IDLE) && ena && dm_ena && (dm_r || dm_w);
        // Ack on the last allowed cycle still wins over the timeout.
        tmo      = (state == REQ) && !mem_ack && (cnt == CNT_W'(TIMEOUT_CYC - 1));
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (launch) state_nx = (acc.ok && !misalign) ? REQ : ERR;
            REQ:  if (mem_ack || tmo) state_nx = DONE;
            DONE: if (ena) state_nx = IDLE;
            ERR:  if (ena) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign stall    = launch || (state == REQ);
    assign mem_req  = (state == REQ);
    assign addr_err = (state == ERR) && ena;
    assign dm_data  = (state == DONE) ? data_q : 32'd0;

    dmem_lane u_lane (
        .st_off  (dm_addr[1:0]),
        .st_size (acc.size),
        .rt      (dm_data_w),
        .be      (st_be),
        .wdata   (st_wdata),
        .ld_off  (off_q),
        .ld_size (size_q),
        .ld_sgn  (sgn_q),
        .rdata   (mem_rdata),
        .ldata   (ld_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_be    <= 4'd0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            off_q     <= 2'd0;
            size_q    <= SZ_BYTE;
            sgn_q     <= 1'b0;
            data_q    <= 32'd0;
            cnt       <= '0;
            bus_err   <= 1'b0;
        end else begin
            state   <= state_nx;
            bus_err <= tmo;
            if (launch) begin
                mem_we    <= acc.store;
                mem_be    <= acc.store ? st_be : BE_ALL;
                mem_addr  <= dm_addr[MEM_AW+1:2];
                mem_wdata <= acc.store ? st_wdata : 32'd0;
                off_q     <= dm_addr[1:0];
                size_q    <= acc.size;
                sgn_q     <= acc.sgn;
                cnt       <= '0;
            end
            if (state == REQ) begin
                if (mem_ack)
                    data_q <= mem_we ? 32'd0 : ld_data;
                else if (tmo)
                    data_q <= 32'd0;
                else
                    cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule
